// File: rtl/lv2_ringbuf_pkg.sv
// lv2_ringbuf_pkg: shared types and constants for the layer-2 ring buffer blocks
package lv2_ringbuf_pkg;
  localparam int AW_DEF = 18;
  localparam int RW_DEF = 16;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;
  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_OVERRUN   = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_LIMIT     = 2'b11;
endpackage

// File: rtl/rb_out_fifo.sv
// rb_out_fifo: 4-entry synchronous output FIFO with occupancy count
module rb_out_fifo #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [2:0]    count
);
  logic [DW-1:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q;
  logic pop_ok;
  assign valid  = cnt_q != 3'd0;
  assign pop_ok = pop && valid;
  assign dout   = valid ? mem_q[rp_q] : '0;
  assign count  = cnt_q;
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + 2'(push);
      rp_q  <= rp_q + 2'(pop_ok);
      cnt_q <= cnt_q + 3'(push) - 3'(pop_ok);
    end
  end
endmodule

// File: rtl/ring_buffer_reader.sv
// ring_buffer_reader: read-side controller of the layer-2 circular event buffer.
// Define RB_READER_USAGE_EN to register the buffer level on usage.
module ring_buffer_reader
  import lv2_ringbuf_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = 32,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] limit,
  input  logic [AW-1:0] wr_addr,
  input  logic [RW-1:0] n_wr,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] rd_addr,
  output logic [RW-1:0] n_rd,
  output logic [1:0]    error,
  output logic [AW-1:0] usage
);
  state_e state_q;
  logic [AW-1:0] limit_q, rd_addr_q, avail;
  logic [RW-1:0] n_rd_q, diff;
  logic [1:0] error_q;
  logic pend_q, same, ahead1, behind, ovr, und, issue, wrap;
  logic [2:0] fifo_cnt;
  assign diff   = n_wr - n_rd_q;
  assign same   = diff == '0;
  assign ahead1 = diff == RW'(1);
  assign behind = diff == '1;
  assign ovr    = (!same && !ahead1 && !behind) || (ahead1 && wr_addr > rd_addr_q);
  assign und    = behind || (same && wr_addr < rd_addr_q);
  assign avail  = (ovr || und) ? '0 : same ? wr_addr - rd_addr_q : limit_q - rd_addr_q + wr_addr;
  // the in-flight word reserves a FIFO slot so backpressure never drops data
  assign issue  = state_q == RUN && enable && !ovr && !und && avail != '0
                  && fifo_cnt + 3'(pend_q) < 3'(FIFO_DEPTH);
  assign wrap   = rd_addr_q == limit_q - AW'(1);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_addr_q;
  assign rd_addr     = rd_addr_q;
  assign n_rd        = n_rd_q;
  assign error       = error_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      rd_addr_q <= '0;
      n_rd_q    <= '0;
      error_q   <= ERR_NONE;
      pend_q    <= 1'b0;
    end else begin
      pend_q <= issue;
      if (issue) begin
        rd_addr_q <= wrap ? '0 : rd_addr_q + AW'(1);
        if (wrap) n_rd_q <= n_rd_q + RW'(1);
      end
      case (state_q)
        IDLE: begin
          limit_q <= limit;
          if (enable) begin
            state_q <= limit < AW'(2) ? ERR : RUN;
            error_q <= limit < AW'(2) ? ERR_LIMIT : ERR_NONE;
          end
        end
        RUN: begin
          if (ovr || und) begin
            state_q <= ERR;
            error_q <= ovr ? ERR_OVERRUN : ERR_UNDERFLOW;
          end else if (!enable && !pend_q) state_q <= IDLE;
        end
        default: state_q <= ERR;
      endcase
    end
  end
  rb_out_fifo #(.DW(DW)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (pend_q),
    .din  (mem_rd_data),
    .pop  (out_ready),
    .dout (out_data),
    .valid(out_valid),
    .count(fifo_cnt)
  );
`ifdef RB_READER_USAGE_EN
  logic [AW-1:0] usage_q;
  always_ff @(posedge clk) usage_q <= reset ? '0 : (ovr || state_q == ERR) ? limit_q : avail;
  assign usage = usage_q;
`else
  assign usage = '0;
`endif
endmodule

// File: tb/tb_ring_buffer_reader.sv
// tb_ring_buffer_reader: scoreboard bench for ring_buffer_reader
module tb_ring_buffer_reader;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int RW = 16;
  logic clk = 0, reset = 1, enable = 0, out_ready = 0;
  logic [AW-1:0] limit = 8, wr_addr = 0, mem_rd_addr, rd_addr, usage;
  logic [RW-1:0] n_wr = 0, n_rd;
  logic [DW-1:0] mem_rd_data = 0, out_data, last_data;
  logic mem_rd_en, out_valid, hold = 0;
  logic [1:0] error;
  int n_tests = 0, n_fail = 0, n_issue = 0, n_pop = 0;
  logic [AW-1:0] exp_addr = 0, tb_limit = 8;
  logic [DW-1:0] sb [$];
  always #5 clk = ~clk;
  ring_buffer_reader #(.AW(AW), .DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .limit(limit), .wr_addr(wr_addr), .n_wr(n_wr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rd_addr(rd_addr), .n_rd(n_rd), .error(error), .usage(usage)
  );
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {14'h2A5, mem_rd_addr};
  always @(negedge clk) if (!reset) begin
    if (mem_rd_en) begin
      n_tests++;
      if (mem_rd_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL issue_addr: got %0d want %0d", mem_rd_addr, exp_addr);
      end
      sb.push_back({14'h2A5, exp_addr});
      exp_addr = (exp_addr == tb_limit - 1) ? '0 : exp_addr + 1;
      n_issue++;
    end
    if (hold && out_valid) begin
      n_tests++;
      if (out_data !== last_data) begin
        n_fail++;
        $display("FAIL data_stable: got %h want %h", out_data, last_data);
      end
    end
    if (out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %h want nothing", out_data);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %h want %h", out_data, e);
        end
      end
      n_pop++;
    end
    hold = out_valid && !out_ready;
    last_data = out_data;
  end
  task automatic do_reset();
    reset = 1; enable = 0; out_ready = 0; wr_addr = 0; n_wr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    sb.delete(); exp_addr = '0; hold = 0;
  endtask
  task automatic wait_issue(input int target, input string nm);
    int k;
    for (k = 0; k < 60 && n_issue < target; k++) begin @(posedge clk); #1; end
    n_tests++;
    if (n_issue != target) begin
      n_fail++;
      $display("FAIL %s_issues: got %0d want %0d", nm, n_issue, target);
    end
  endtask
  task automatic wait_drain(input string nm);
    int k;
    for (k = 0; k < 60 && (sb.size() != 0 || out_valid); k++) begin @(posedge clk); #1; end
    n_tests++;
    if (sb.size() != 0 || out_valid) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending want 0", nm, sb.size());
    end
  endtask
  task automatic test_reset();
    do_reset();
    n_tests += 4;
    if (rd_addr !== 0 || n_rd !== 0) begin n_fail++; $display("FAIL reset_ptr: got %0d/%0d want 0/0", rd_addr, n_rd); end
    if (error !== 2'b00) begin n_fail++; $display("FAIL reset_error: got %b want 00", error); end
    if ({out_valid, mem_rd_en} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {out_valid, mem_rd_en}); end
    if (out_data !== 0 || usage !== 0) begin n_fail++; $display("FAIL reset_data: got %h/%0d want 0/0", out_data, usage); end
  endtask
  task automatic test_basic();
    int s = n_pop;
    tb_limit = 8; limit = 8; wr_addr = 5; n_wr = 0; out_ready = 1; enable = 1;
    wait_issue(5, "basic");
    wait_drain("basic");
    n_tests += 3;
    if (rd_addr !== 5 || n_rd !== 0) begin n_fail++; $display("FAIL basic_ptr: got %0d/%0d want 5/0", rd_addr, n_rd); end
    if (error !== 2'b00) begin n_fail++; $display("FAIL basic_error: got %b want 00", error); end
    if (n_pop - s != 5) begin n_fail++; $display("FAIL basic_words: got %0d want 5", n_pop - s); end
  endtask
  task automatic test_wrap();
    int t0 = -1, t1 = -1, base;
    wr_addr = 6;
    wait_issue(6, "pre_wrap");
    wait_drain("pre_wrap");
    base = n_issue;
    wr_addr = 2; n_wr = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (t0 < 0 && n_issue > base) t0 = k;
      if (n_issue >= base + 4) begin t1 = k; break; end
    end
    n_tests++;
    if (t1 < 0 || t1 - t0 != 3) begin n_fail++; $display("FAIL wrap_throughput: got span %0d want 3", t1 - t0); end
    wait_drain("wrap");
    n_tests += 2;
    if (rd_addr !== 2 || n_rd !== 1) begin n_fail++; $display("FAIL wrap_ptr: got %0d/%0d want 2/1", rd_addr, n_rd); end
    if (error !== 2'b00) begin n_fail++; $display("FAIL wrap_error: got %b want 00", error); end
  endtask
  task automatic test_full();
    int base;
    @(posedge clk); #1;
    wr_addr = 3;
    wait_issue(n_issue + 1, "pre_full");
    wait_drain("pre_full");
    base = n_issue;
    n_wr = 2;
    @(posedge clk); #1;
`ifdef RB_READER_USAGE_EN
    n_tests++;
    if (usage !== 8) begin n_fail++; $display("FAIL full_usage: got %0d want 8", usage); end
`endif
    wait_issue(base + 8, "full");
    wait_drain("full");
    n_tests += 2;
    if (rd_addr !== 3 || n_rd !== 2) begin n_fail++; $display("FAIL full_ptr: got %0d/%0d want 3/2", rd_addr, n_rd); end
    if (error !== 2'b00) begin n_fail++; $display("FAIL full_error: got %b want 00", error); end
  endtask
  task automatic test_backpressure();
    int base = n_issue, s = n_pop;
    out_ready = 0; n_wr = 3;
    repeat (10) @(posedge clk);
    #1;
    n_tests += 2;
    if (n_issue - base != 4) begin n_fail++; $display("FAIL bp_issues: got %0d want 4", n_issue - base); end
    if (n_pop != s || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got pops %0d valid %b want 0/1", n_pop - s, out_valid); end
    out_ready = 1;
    wait_issue(base + 8, "bp");
    wait_drain("bp");
    n_tests += 2;
    if (n_pop - s != 8) begin n_fail++; $display("FAIL bp_words: got %0d want 8", n_pop - s); end
    if (rd_addr !== 3 || n_rd !== 3) begin n_fail++; $display("FAIL bp_ptr: got %0d/%0d want 3/3", rd_addr, n_rd); end
  endtask
  task automatic test_overrun();
    int base = n_issue;
    n_wr = 5;
    #1;
    n_tests++;
    if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL ovr_detect_issue: got %b want 0", mem_rd_en); end
    @(posedge clk); #1;
    n_tests++;
    if (error !== 2'b01) begin n_fail++; $display("FAIL ovr_error: got %b want 01", error); end
    n_wr = 4;
    repeat (5) @(posedge clk);
    #1;
    n_tests += 2;
    if (error !== 2'b01) begin n_fail++; $display("FAIL ovr_sticky: got %b want 01", error); end
    if (n_issue != base) begin n_fail++; $display("FAIL ovr_no_reads: got %0d want 0", n_issue - base); end
  endtask
  task automatic test_underflow();
    do_reset();
    tb_limit = 8; limit = 8; wr_addr = 0; n_wr = 0; enable = 1;
    repeat (2) @(posedge clk);
    #1 n_wr = 16'hFFFF;
    @(posedge clk); #1;
    n_tests++;
    if (error !== 2'b10) begin n_fail++; $display("FAIL und_error: got %b want 10", error); end
  endtask
  task automatic test_bad_limit();
    int base;
    do_reset();
    tb_limit = 1; limit = 1; wr_addr = 5; enable = 1;
    base = n_issue;
    @(posedge clk); #1;
    n_tests++;
    if (error !== 2'b11) begin n_fail++; $display("FAIL limit_error: got %b want 11", error); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (n_issue != base || error !== 2'b11) begin n_fail++; $display("FAIL limit_hold: got %0d reads err %b want 0/11", n_issue - base, error); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    tb_limit = 8; limit = 8; wr_addr = 7; n_wr = 0; out_ready = 0; enable = 1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    reset = 1;
    @(posedge clk); #1;
    n_tests += 2;
    if ({out_valid, mem_rd_en, error} !== 4'b0 || out_data !== 0) begin n_fail++; $display("FAIL mid_reset_out: got %b %h want 0", {out_valid, mem_rd_en, error}, out_data); end
    if (rd_addr !== 0 || n_rd !== 0 || usage !== 0) begin n_fail++; $display("FAIL mid_reset_ptr: got %0d/%0d/%0d want 0", rd_addr, n_rd, usage); end
    do_reset();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_backpressure();
    test_overrun();
    test_underflow();
    test_bad_limit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
